reg_wb_queue: RTL

- Write-back side of the 8x8 register bank: buffers ALU/load results as (destination, data) pairs and issues one bank write per cycle on the bank's write port (address, load-enable, 8-bit data).
- Sits between the execute stage and the register bank.
- Flags read-after-write hazards for the two bank read addresses (Rx/Ry) while a write to either is still queued or in flight.

---
 rtl/reg_wb_queue_pkg.sv | 16 +
 rtl/reg_wb_queue_fifo.sv | 75 +++++++
 rtl/reg_wb_queue.sv | 107 ++++++++++
 3 files changed

// File: rtl/reg_wb_queue_pkg.sv
// reg_wb_queue_pkg
// Shared constants for the register-bank write-back queue:
//   REG_AW / REG_DW  register address and data widths of the 8x8 bank
//   NUM_REGS         number of registers in the bank
//   ST_*             FSM state encoding used by the queue controller
package reg_wb_queue_pkg;

    localparam int REG_AW   = 3;
    localparam int REG_DW   = 8;
    localparam int NUM_REGS = 8;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/reg_wb_queue_fifo.sv
// wbq_fifo
// Storage for queued (address, data) write-back entries.
//   clk, rst               clock, synchronous active-high reset
//   push, push_addr/data   enqueue one entry at the tail
//   pop                    dequeue the head entry
//   head_addr/head_data    current head entry
//   count                  number of valid entries
//   cmp_x_addr/cmp_y_addr  addresses compared against every valid entry
//   match_x/match_y        per-entry hit: entry valid and address equal
// The caller guarantees push only when not full and pop only when not empty.
module wbq_fifo
    import reg_wb_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int AW    = REG_AW,
    parameter  int DW    = REG_DW,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [AW-1:0]        push_addr,
    input  logic [DW-1:0]        push_data,
    input  logic                 pop,
    output logic [AW-1:0]        head_addr,
    output logic [DW-1:0]        head_data,
    output logic [CW-1:0]        count,
    input  logic [AW-1:0]        cmp_x_addr,
    input  logic [AW-1:0]        cmp_y_addr,
    output logic [DEPTH-1:0]     match_x,
    output logic [DEPTH-1:0]     match_y
);

    logic [DEPTH-1:0][AW-1:0] mem_addr;
    logic [DEPTH-1:0][DW-1:0] mem_data;
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [DEPTH-1:0]         ent_vld;

    // Pointers wrap naturally because DEPTH is a power of two;
    // count tells full from empty when the pointers are equal.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Payload needs no reset: an entry is only ever read once count covers it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_data[wr_ptr] <= push_data;
        end
    end

    assign head_addr = mem_addr[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    // An entry is valid when its distance from the head is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PW-1:0] ofs;
        assign ofs        = PW'(i) - rd_ptr;
        assign ent_vld[i] = CW'(ofs) < count;
        assign match_x[i] = ent_vld[i] && (mem_addr[i] == cmp_x_addr);
        assign match_y[i] = ent_vld[i] && (mem_addr[i] == cmp_y_addr);
    end

endmodule

// File: rtl/reg_wb_queue.sv
// reg_wb_queue
// Write-back queue in front of the register bank write port.
//   Clk, Rst                     clock, synchronous active-high reset
//   in_valid/in_ready            result handshake from execute
//   in_addr/in_data              destination register and value
//   wb_hold                      bank write port busy this cycle
//   wb_addr/wb_le/wb_data        registered bank write port
//   rd_x_addr/rd_y_addr          bank read addresses to check
//   hazard_x/hazard_y            write pending to that read address
//   drain_req/drained            drain handshake (blocks new input)
//   count                        number of queued entries
module reg_wb_queue
    import reg_wb_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int AW    = REG_AW,
    parameter  int DW    = REG_DW,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    input  logic          wb_hold,
    output logic [AW-1:0] wb_addr,
    output logic          wb_le,
    output logic [DW-1:0] wb_data,
    input  logic [AW-1:0] rd_x_addr,
    input  logic [AW-1:0] rd_y_addr,
    output logic          hazard_x,
    output logic          hazard_y,
    input  logic          drain_req,
    output logic          drained,
    output logic [CW-1:0] count
);

    logic [1:0]       state;
    logic             push;
    logic             pop;
    logic [AW-1:0]    head_addr;
    logic [DW-1:0]    head_data;
    logic [DEPTH-1:0] match_x;
    logic [DEPTH-1:0] match_y;

    // in_ready comes from the registered count, so a pop on a full queue
    // does not open a slot until the next cycle.
    assign in_ready = (count < CW'(DEPTH)) && (state == ST_RUN);
    assign push     = in_valid && in_ready;
    assign pop      = (count != '0) && !wb_hold;
    assign drained  = (count == '0) && !wb_le;

    wbq_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk        (Clk),
        .rst        (Rst),
        .push       (push),
        .push_addr  (in_addr),
        .push_data  (in_data),
        .pop        (pop),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .count      (count),
        .cmp_x_addr (rd_x_addr),
        .cmp_y_addr (rd_y_addr),
        .match_x    (match_x),
        .match_y    (match_y)
    );

    // Bank write port: wb_le pulses for the cycle after each pop,
    // address/data hold their last value otherwise.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wb_le   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            wb_le <= pop;
            if (pop) begin
                wb_addr <= head_addr;
                wb_data <= head_data;
            end
        end
    end

    // The write currently on the bank port still counts as pending.
    assign hazard_x = (|match_x) || (wb_le && (wb_addr == rd_x_addr));
    assign hazard_y = (|match_y) || (wb_le && (wb_addr == rd_y_addr));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:   if (drain_req) state <= ST_DRAIN;
                ST_DRAIN: if (drained)   state <= ST_DONE;
                ST_DONE:  if (!drain_req) state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

endmodule
